// File: rtl/tc5_adder_arbiter.sv
`default_nettype none
// ============================================================================
// tc5_adder_arbiter : round-robin share of one mod-5 thermometer-code adder
// Revision 1.0
// ============================================================================
module tc5_adder_arbiter #(
  parameter int NREQ  = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [4*NREQ-1:0] req_a_i,
  input  logic [4*NREQ-1:0] req_b_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [3:0]        rsp_sum_o,
  output logic [ID_W-1:0]   rsp_id_o,
  output logic              rsp_err_o,
  output logic [CNT_W-1:0]  ops_cnt_o
);

  function automatic logic therm_legal(input logic [3:0] c);
    return (c == 4'b0000) || (c == 4'b0001) || (c == 4'b0011) ||
           (c == 4'b0111) || (c == 4'b1111);
  endfunction

  function automatic logic [2:0] therm_val(input logic [3:0] c);
    case (c)
      4'b0001: return 3'd1;
      4'b0011: return 3'd2;
      4'b0111: return 3'd3;
      4'b1111: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] therm_enc(input logic [2:0] k);
    case (k)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      3'd4:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  logic              rsp_valid_q;
  logic [3:0]        rsp_sum_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic              rsp_err_q;
  logic [CNT_W-1:0]  ops_cnt_q;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   ptr_d;

  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic [3:0]        gnt_a;
  logic [3:0]        gnt_b;
  logic              slot_free;
  logic              xfer;
  logic [3:0]        sum_raw;
  logic [2:0]        sum_mod;
  logic              err_d;
  logic [3:0]        sum_d;

  // Scan from the pointer upward, wrapping; the first valid requester wins.
  always_comb begin : p_arb
    int idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_a     = '0;
    gnt_b     = '0;
    idx       = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr_q) + off) % NREQ;
      if (!gnt_found && req_valid_i[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
        gnt_a     = req_a_i[4*idx +: 4];
        gnt_b     = req_b_i[4*idx +: 4];
      end
    end
  end

  assign slot_free   = !rsp_valid_q || rsp_ready_i;
  assign xfer        = slot_free && gnt_found;
  assign req_ready_o = (xfer && rst_n) ? (NREQ'(1) << gnt_idx) : '0;
  assign ptr_d       = (gnt_idx == ID_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;

  // Shared adder: operands are 0..4, so one conditional subtract reduces mod 5.
  assign sum_raw = {1'b0, therm_val(gnt_a)} + {1'b0, therm_val(gnt_b)};
  assign sum_mod = (sum_raw >= 4'd5) ? 3'(sum_raw - 4'd5) : sum_raw[2:0];
  assign err_d   = !therm_legal(gnt_a) || !therm_legal(gnt_b);
  assign sum_d   = err_d ? 4'b0000 : therm_enc(sum_mod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
      ops_cnt_q   <= '0;
      ptr_q       <= '0;
    end else begin
      if (xfer) begin
        rsp_valid_q <= 1'b1;
        rsp_sum_q   <= sum_d;
        rsp_id_q    <= gnt_idx;
        rsp_err_q   <= err_d;
        ptr_q       <= ptr_d;
      end else if (rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end
      if (rsp_valid_q && rsp_ready_i) begin
        ops_cnt_q <= ops_cnt_q + CNT_W'(1);
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_sum_o   = rsp_sum_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_err_o   = rsp_err_q;
  assign ops_cnt_o   = ops_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tc5_adder_arbiter.sv
`default_nettype none
// ============================================================================
// tb_tc5_adder_arbiter : scoreboard bench for the shared mod-5 adder arbiter
// Revision 1.0
// ============================================================================
module tb_tc5_adder_arbiter;
  localparam int NREQ  = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 16;
  localparam int DEPTH = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_a = '0;
  logic [4*NREQ-1:0] req_b = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [3:0]        rsp_sum;
  logic [ID_W-1:0]   rsp_id;
  logic              rsp_err;
  logic [CNT_W-1:0]  ops_cnt;

  tc5_adder_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_sum_o   (rsp_sum),
    .rsp_id_o    (rsp_id),
    .rsp_err_o   (rsp_err),
    .ops_cnt_o   (ops_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]      sum;
    logic [ID_W-1:0] id;
    logic            err;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_bad = 0;
  logic [3:0] opa [NREQ][DEPTH];
  logic [3:0] opb [NREQ][DEPTH];
  int         head [NREQ];
  int         tail [NREQ];
  logic       hs [NREQ];
  logic [3:0] c_code [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic enq(input int r, input logic [3:0] a, input logic [3:0] b);
    opa[r][tail[r]] = a;
    opb[r][tail[r]] = b;
    tail[r]++;
  endtask

  task automatic expect_rsp(input logic [3:0] s, input int id, input logic e);
    exp_t x;
    x.sum = s;
    x.id  = ID_W'(id);
    x.err = e;
    sb.push_back(x);
  endtask

  task automatic wait_drain(input int lim);
    int k;
    k = 0;
    while (sb.size() != 0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain timeout: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_valid(input int lim);
    int k;
    k = 0;
    @(negedge clk);
    while (!rsp_valid && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("wait rsp_valid", 32'(rsp_valid), 32'd1);
  endtask

  task automatic flush_stim();
    for (int i = 0; i < NREQ; i++) tail[i] = head[i];
    sb.delete();
  endtask

  // Requester driver: each requester presents its queue head until it is accepted.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i] && head[i] < tail[i]) head[i]++;
        if (head[i] < tail[i]) begin
          req_valid[i]     = 1'b1;
          req_a[4*i +: 4]  = opa[i][head[i]];
          req_b[4*i +: 4]  = opb[i][head[i]];
        end else begin
          req_valid[i]     = 1'b0;
        end
      end
    end
  end

  // Monitor: records accepted requests and checks every drained response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) hs[i] = req_valid[i] & req_ready[i];
      if (rst_n) begin
        n_vec++;
        if ($countones(req_ready) > 1) begin
          n_bad++;
          $display("FAIL req_ready onehot: got %b, expected at most one bit", req_ready);
        end
        if (rsp_valid && rsp_ready) begin
          n_vec++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL rsp unexpected: got sum=%b id=%0d err=%b, expected none",
                     rsp_sum, rsp_id, rsp_err);
          end else begin
            e = sb.pop_front();
            if (rsp_sum !== e.sum || rsp_id !== e.id || rsp_err !== e.err) begin
              n_bad++;
              $display("FAIL rsp: got sum=%b id=%0d err=%b, expected sum=%b id=%0d err=%b",
                       rsp_sum, rsp_id, rsp_err, e.sum, e.id, e.err);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first;
    int last;
    int cnt;
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
      hs[i]   = 1'b0;
    end
    c_code[0] = 4'b0000;
    c_code[1] = 4'b0001;
    c_code[2] = 4'b0011;
    c_code[3] = 4'b0111;
    c_code[4] = 4'b1111;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_sum",   32'(rsp_sum),   32'd0);
    chk("reset rsp_id",    32'(rsp_id),    32'd0);
    chk("reset rsp_err",   32'(rsp_err),   32'd0);
    chk("reset ops_cnt",   32'(ops_cnt),   32'd0);
    chk("reset req_ready", 32'(req_ready), 32'd0);
    #2 rst_n = 1'b1;

    // Single request: 2 + 3 = 5 -> 0
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    enq(0, 4'b0011, 4'b0111);
    expect_rsp(4'b0000, 0, 1'b0);
    wait_drain(20);
    chk("single ops_cnt", 32'(ops_cnt), 32'd1);

    // All 25 legal pairs on requester 2
    for (int ka = 0; ka < 5; ka++) begin
      for (int kb = 0; kb < 5; kb++) begin
        enq(2, c_code[ka], c_code[kb]);
        expect_rsp(c_code[(ka + kb) % 5], 2, 1'b0);
      end
    end
    wait_drain(60);
    chk("exhaustive ops_cnt", 32'(ops_cnt), 32'd26);

    // Round-robin from a fresh pointer
    @(negedge clk); #2 rst_n = 1'b0;
    flush_stim();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;
    enq(0, 4'b0001, 4'b0001); enq(0, 4'b1111, 4'b1111);
    enq(1, 4'b0000, 4'b0000); enq(1, 4'b0011, 4'b0111);
    enq(2, 4'b0111, 4'b0001); enq(2, 4'b0000, 4'b1111);
    enq(3, 4'b1111, 4'b0011); enq(3, 4'b0001, 4'b0000);
    expect_rsp(4'b0011, 0, 1'b0);
    expect_rsp(4'b0000, 1, 1'b0);
    expect_rsp(4'b1111, 2, 1'b0);
    expect_rsp(4'b0001, 3, 1'b0);
    expect_rsp(4'b0111, 0, 1'b0);
    expect_rsp(4'b0000, 1, 1'b0);
    expect_rsp(4'b1111, 2, 1'b0);
    expect_rsp(4'b0001, 3, 1'b0);
    first = -1; last = -1; cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (first < 0) first = c;
        last = c;
        cnt++;
      end
    end
    chk("rr result count", 32'(cnt), 32'd8);
    chk("rr back-to-back span", 32'(last - first + 1), 32'd8);
    wait_drain(5);
    chk("rr ops_cnt", 32'(ops_cnt), 32'd8);

    // Backpressure: 1 + 2 = 3 on req1 held, 4 + 1 = 0 on req3 waiting
    @(posedge clk); #2;
    rsp_ready = 1'b0;
    enq(1, 4'b0001, 4'b0011);
    enq(3, 4'b1111, 4'b0001);
    expect_rsp(4'b0111, 1, 1'b0);
    expect_rsp(4'b0000, 3, 1'b0);
    wait_valid(10);
    for (int c = 0; c < 5; c++) begin
      chk("bp rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp rsp_sum",   32'(rsp_sum),   32'b0111);
      chk("bp rsp_id",    32'(rsp_id),    32'd1);
      chk("bp req_ready", 32'(req_ready), 32'd0);
      if (c < 4) @(negedge clk);
    end
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp release grant", 32'(req_ready), 32'b1000);
    @(negedge clk);
    chk("bp no bubble valid", 32'(rsp_valid), 32'd1);
    chk("bp no bubble id",    32'(rsp_id),    32'd3);
    wait_drain(10);
    chk("bp ops_cnt", 32'(ops_cnt), 32'd10);

    // Illegal operand
    enq(1, 4'b0101, 4'b0001);
    expect_rsp(4'b0000, 1, 1'b1);
    wait_drain(10);
    chk("illegal ops_cnt", 32'(ops_cnt), 32'd11);
    chk("illegal err held", 32'(rsp_err), 32'd1);
    chk("illegal valid dropped", 32'(rsp_valid), 32'd0);

    // Reset with a stalled response pending
    @(posedge clk); #2;
    rsp_ready = 1'b0;
    enq(2, 4'b0001, 4'b0001);
    expect_rsp(4'b0011, 2, 1'b0);
    wait_valid(10);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset ops_cnt",   32'(ops_cnt),   32'd0);
    chk("midreset rsp_id",    32'(rsp_id),    32'd0);
    flush_stim();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    enq(3, 4'b0001, 4'b1111);
    enq(0, 4'b0011, 4'b0001);
    expect_rsp(4'b0111, 0, 1'b0);
    expect_rsp(4'b0000, 3, 1'b0);
    wait_drain(10);
    chk("post-reset ops_cnt", 32'(ops_cnt), 32'd2);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
